// File: rtl/pcie_write_bw_gen.sv
// rtl/pcie_write_bw_gen.sv - AXI4 write-only PCIe bandwidth generator.
// Optional beat-index data pattern enabled by PCIE_WR_BW_PATTERN_EN.
module pcie_write_bw_gen #(
  parameter int          DW              = 512,
  parameter int          IW              = 4,
  parameter int          BURST_BYTES     = 4096,
  parameter int          MAX_OUTSTANDING = 16,
  parameter logic [63:0] PCI_BASE_ADDR   = 64'h1_0000_0000,
  parameter logic [63:0] WINDOW_BYTES    = 64'h1_0000_0000
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            start_i,
  input  logic [31:0]     num_bursts_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [63:0]     elapsed_cycles_o,
  output logic [31:0]     bresp_errors_o,
  output logic [63:0]     m_axi_awaddr_o,
  output logic [7:0]      m_axi_awlen_o,
  output logic [2:0]      m_axi_awsize_o,
  output logic [1:0]      m_axi_awburst_o,
  output logic [IW-1:0]   m_axi_awid_o,
  output logic            m_axi_awlock_o,
  output logic [3:0]      m_axi_awcache_o,
  output logic [2:0]      m_axi_awprot_o,
  output logic [3:0]      m_axi_awqos_o,
  output logic            m_axi_awvalid_o,
  input  logic            m_axi_awready_i,
  output logic [DW-1:0]   m_axi_wdata_o,
  output logic [DW/8-1:0] m_axi_wstrb_o,
  output logic            m_axi_wlast_o,
  output logic            m_axi_wvalid_o,
  input  logic            m_axi_wready_i,
  input  logic [1:0]      m_axi_bresp_i,
  input  logic            m_axi_bvalid_i,
  output logic            m_axi_bready_o
);

  localparam int          BEATS     = BURST_BYTES / (DW / 8);
  localparam logic [7:0]  LAST_BEAT = 8'(BEATS - 1);
  localparam logic [2:0]  SIZE      = 3'($clog2(DW / 8));
  localparam logic [63:0] BURST_B   = 64'(BURST_BYTES);
  localparam logic [31:0] MAX_OUT   = 32'(MAX_OUTSTANDING);

  typedef enum logic { AW_IDLE, AW_ISSUE } aw_state_t;
  typedef enum logic { W_IDLE,  W_BURST  } w_state_t;

  aw_state_t   aw_state_q, aw_state_d;
  w_state_t    w_state_q,  w_state_d;
  logic        busy_q,     busy_d;
  logic [31:0] n_q,        n_d;
  logic [31:0] aw_cnt_q,   aw_cnt_d;
  logic [31:0] w_cnt_q,    w_cnt_d;
  logic [31:0] b_cnt_q,    b_cnt_d;
  logic [63:0] elapsed_q,  elapsed_d;
  logic [31:0] err_q,      err_d;
  logic [63:0] aw_off_q,   aw_off_d;
  logic [7:0]  beat_q,     beat_d;
`ifdef PCIE_WR_BW_PATTERN_EN
  logic [31:0] idx_q,      idx_d;
`endif

  logic start_ok, aw_hs, w_hs, b_hs, final_b;

  assign start_ok = start_i & ~busy_q;
  assign aw_hs    = (aw_state_q == AW_ISSUE) & m_axi_awready_i;
  assign w_hs     = (w_state_q == W_BURST) & m_axi_wready_i;
  assign b_hs     = busy_q & m_axi_bvalid_i;
  // An empty run completes on its first busy cycle.
  assign final_b  = busy_q & ((n_q == 32'd0) | (b_hs & (b_cnt_q == n_q - 32'd1)));

  always_comb begin
    busy_d     = busy_q;
    n_d        = n_q;
    aw_cnt_d   = aw_cnt_q;
    w_cnt_d    = w_cnt_q;
    b_cnt_d    = b_cnt_q;
    elapsed_d  = elapsed_q;
    err_d      = err_q;
    aw_state_d = aw_state_q;
    aw_off_d   = aw_off_q;
    w_state_d  = w_state_q;
    beat_d     = beat_q;
`ifdef PCIE_WR_BW_PATTERN_EN
    idx_d      = idx_q;
`endif
    if (start_ok) begin
      busy_d     = 1'b1;
      n_d        = num_bursts_i;
      aw_cnt_d   = '0;
      w_cnt_d    = '0;
      b_cnt_d    = '0;
      elapsed_d  = '0;
      err_d      = '0;
      aw_state_d = AW_IDLE;
      aw_off_d   = '0;
      w_state_d  = W_IDLE;
      beat_d     = '0;
`ifdef PCIE_WR_BW_PATTERN_EN
      idx_d      = '0;
`endif
    end else if (busy_q) begin
      elapsed_d = elapsed_q + 64'd1;
      if (b_hs) begin
        b_cnt_d = b_cnt_q + 32'd1;
        if (m_axi_bresp_i != 2'b00 && err_q != 32'hFFFF_FFFF) err_d = err_q + 32'd1;
      end
      case (aw_state_q)
        AW_IDLE: begin
          if (aw_cnt_q < n_q && (aw_cnt_q - b_cnt_q) < MAX_OUT) aw_state_d = AW_ISSUE;
        end
        default: begin
          if (aw_hs) begin
            aw_cnt_d   = aw_cnt_q + 32'd1;
            aw_state_d = AW_IDLE;
            aw_off_d   = (aw_off_q + BURST_B == WINDOW_BYTES) ? 64'd0 : aw_off_q + BURST_B;
          end
        end
      endcase
      case (w_state_q)
        W_IDLE: begin
          if (w_cnt_q < aw_cnt_q) w_state_d = W_BURST;
        end
        default: begin
          if (w_hs) begin
            beat_d = beat_q + 8'd1;
`ifdef PCIE_WR_BW_PATTERN_EN
            idx_d  = idx_q + 32'd1;
`endif
            if (beat_q == LAST_BEAT) begin
              beat_d  = '0;
              w_cnt_d = w_cnt_q + 32'd1;
              // Keep WVALID up into the next burst if its AW is already accepted.
              if (w_cnt_q + 32'd1 >= aw_cnt_d) w_state_d = W_IDLE;
            end
          end
        end
      endcase
      if (final_b) begin
        busy_d     = 1'b0;
        aw_state_d = AW_IDLE;
        w_state_d  = W_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      busy_q     <= 1'b0;
      n_q        <= '0;
      aw_cnt_q   <= '0;
      w_cnt_q    <= '0;
      b_cnt_q    <= '0;
      elapsed_q  <= '0;
      err_q      <= '0;
      aw_state_q <= AW_IDLE;
      aw_off_q   <= '0;
      w_state_q  <= W_IDLE;
      beat_q     <= '0;
`ifdef PCIE_WR_BW_PATTERN_EN
      idx_q      <= '0;
`endif
    end else begin
      busy_q     <= busy_d;
      n_q        <= n_d;
      aw_cnt_q   <= aw_cnt_d;
      w_cnt_q    <= w_cnt_d;
      b_cnt_q    <= b_cnt_d;
      elapsed_q  <= elapsed_d;
      err_q      <= err_d;
      aw_state_q <= aw_state_d;
      aw_off_q   <= aw_off_d;
      w_state_q  <= w_state_d;
      beat_q     <= beat_d;
`ifdef PCIE_WR_BW_PATTERN_EN
      idx_q      <= idx_d;
`endif
    end
  end

  assign busy_o           = busy_q;
  assign done_o           = final_b;
  assign elapsed_cycles_o = elapsed_q;
  assign bresp_errors_o   = err_q;

  assign m_axi_awaddr_o   = PCI_BASE_ADDR + aw_off_q;
  assign m_axi_awlen_o    = LAST_BEAT;
  assign m_axi_awsize_o   = SIZE;
  assign m_axi_awburst_o  = 2'b01;
  assign m_axi_awid_o     = '0;
  assign m_axi_awlock_o   = 1'b0;
  assign m_axi_awcache_o  = 4'd0;
  assign m_axi_awprot_o   = 3'd0;
  assign m_axi_awqos_o    = 4'd0;
  assign m_axi_awvalid_o  = (aw_state_q == AW_ISSUE);

`ifdef PCIE_WR_BW_PATTERN_EN
  assign m_axi_wdata_o    = {(DW/32){idx_q}};
`else
  assign m_axi_wdata_o    = '0;
`endif
  assign m_axi_wstrb_o    = '1;
  assign m_axi_wvalid_o   = (w_state_q == W_BURST);
  assign m_axi_wlast_o    = (w_state_q == W_BURST) & (beat_q == LAST_BEAT);
  assign m_axi_bready_o   = 1'b1;

endmodule

// File: tb/tb_pcie_write_bw_gen.sv
// tb/tb_pcie_write_bw_gen.sv - randomized self-checking bench for pcie_write_bw_gen.
module tb_pcie_write_bw_gen;

  localparam int          DW    = 512;
  localparam int          IW    = 4;
  localparam int          BURST = 4096;
  localparam int          BEATS = BURST / (DW / 8);
  localparam int          MAXO  = 2;
  localparam logic [63:0] BASE  = 64'h1_0000_0000;
  localparam logic [63:0] WIN   = 64'h4000;

  logic            clk = 0;
  logic            resetn = 0;
  logic            start_i = 0;
  logic [31:0]     num_bursts_i = 0;
  logic            busy_o, done_o;
  logic [63:0]     elapsed_o;
  logic [31:0]     errs_o;
  logic [63:0]     awaddr;
  logic [7:0]      awlen;
  logic [2:0]      awsize, awprot;
  logic [1:0]      awburst;
  logic [IW-1:0]   awid;
  logic            awlock, awvalid, wlast, wvalid, bready;
  logic [3:0]      awcache, awqos;
  logic            awready = 1, wready = 1, bvalid = 0;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic [1:0]      bresp = 0;

  pcie_write_bw_gen #(.DW(DW), .IW(IW), .BURST_BYTES(BURST), .MAX_OUTSTANDING(MAXO),
                      .PCI_BASE_ADDR(BASE), .WINDOW_BYTES(WIN)) dut (
    .clk(clk), .resetn(resetn), .start_i(start_i), .num_bursts_i(num_bursts_i),
    .busy_o(busy_o), .done_o(done_o), .elapsed_cycles_o(elapsed_o), .bresp_errors_o(errs_o),
    .m_axi_awaddr_o(awaddr), .m_axi_awlen_o(awlen), .m_axi_awsize_o(awsize),
    .m_axi_awburst_o(awburst), .m_axi_awid_o(awid), .m_axi_awlock_o(awlock),
    .m_axi_awcache_o(awcache), .m_axi_awprot_o(awprot), .m_axi_awqos_o(awqos),
    .m_axi_awvalid_o(awvalid), .m_axi_awready_i(awready),
    .m_axi_wdata_o(wdata), .m_axi_wstrb_o(wstrb), .m_axi_wlast_o(wlast),
    .m_axi_wvalid_o(wvalid), .m_axi_wready_i(wready),
    .m_axi_bresp_i(bresp), .m_axi_bvalid_i(bvalid), .m_axi_bready_o(bready)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_fail = 0, cyc = 0;
  // Reference model state: a run is a count of bursts, each with AW / W / B milestones.
  bit   exp_busy = 0;
  int   run_n, start_cyc, done_cyc, elapsed_exp, exp_err;
  int   aw_acc, w_done, w_beats, b_rcv, max_out, done_pulses, aw_valid_cycles, w_valid_cycles;
  int   aw_cyc[64], comp_cyc[64];
  logic [1:0]  plan[64];
  logic [63:0] aw_addr_log[$];
  int   wlast_log[$];
  logic [31:0] first_w32;
  int   stall_en = 0, b_delay = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] exp_wdata(input int idx);
    logic [DW-1:0] d = '0;
`ifdef PCIE_WR_BW_PATTERN_EN
    for (int i = 0; i < DW/32; i++) d[i*32 +: 32] = 32'(idx);
`endif
    return d;
  endfunction

  // Slave: random ready stalls; one B per completed burst, b_delay cycles after completion.
  always begin
    @(posedge clk); #1;
    awready = stall_en != 0 ? ($urandom_range(0, 2) != 0) : 1'b1;
    wready  = stall_en != 0 ? ($urandom_range(0, 2) != 0) : 1'b1;
    bvalid  = 1'b0;
    bresp   = 2'b00;
    if (resetn && exp_busy && b_rcv < w_done && b_rcv < 64 && cyc >= comp_cyc[b_rcv] + b_delay) begin
      bvalid = 1'b1;
      bresp  = plan[b_rcv];
    end
  end

  logic [63:0]   aw_addr_prev;
  logic [DW-1:0] wdata_prev, ed;
  logic          wlast_prev, aw_stall_prev = 0, w_stall_prev = 0, exp_done, exp_last, was_busy;

  always @(negedge clk) begin
    if (!resetn) begin
      exp_busy = 0; run_n = 0; aw_acc = 0; w_done = 0; w_beats = 0; b_rcv = 0;
      exp_err = 0; elapsed_exp = 0; aw_stall_prev = 0; w_stall_prev = 0;
    end else begin
      was_busy = exp_busy;
      exp_done = exp_busy && (run_n == 0 || (bvalid && b_rcv == run_n - 1));
      chk("busy", busy_o, exp_busy);
      chk("done", done_o, exp_done);
      chk("bready", bready, 1'b1);
      if (exp_busy) chk("elapsed_run", elapsed_o, 64'(cyc - start_cyc - 1));
      else          chk("elapsed_hold", elapsed_o, 64'(elapsed_exp));
      chk("bresp_errors", errs_o, 64'(exp_err));
      if (!exp_busy) chk("idle_quiet", {awvalid, wvalid, wlast}, 0);
      if (aw_stall_prev) begin
        chk("aw_hold_valid", awvalid, 1'b1);
        chk("aw_hold_addr", awaddr, aw_addr_prev);
      end
      if (w_stall_prev) begin
        chk("w_hold_valid", wvalid, 1'b1);
        chk("w_hold_data", wdata == wdata_prev, 1'b1);
        chk("w_hold_last", wlast, wlast_prev);
      end
      if (wvalid) begin
        w_valid_cycles++;
        chk("w_after_aw", w_done < aw_acc, 1'b1);
      end
      if (awvalid) begin
        aw_valid_cycles++;
        chk("aw_gate", (aw_acc < run_n) && (aw_acc - b_rcv < MAXO), 1'b1);
      end
      if (wvalid && wready) begin
        exp_last = (w_beats % BEATS) == BEATS - 1;
        ed = exp_wdata(w_beats);
        chk("wlast", wlast, exp_last);
        chk("wdata_lo", wdata[63:0], ed[63:0]);
        chk("wdata_all", wdata == ed, 1'b1);
        chk("wstrb", &wstrb, 1'b1);
        if (w_beats == 0) first_w32 = wdata[31:0];
        if (exp_last) begin
          wlast_log.push_back(w_beats);
          if (w_done < 64) comp_cyc[w_done] = (cyc > aw_cyc[w_done]) ? cyc : aw_cyc[w_done];
          w_done++;
        end
        w_beats++;
      end
      if (awvalid && awready) begin
        chk("awaddr", awaddr, BASE + ((64'(aw_acc) * 64'(BURST)) % WIN));
        chk("aw_attr", {awlen, awsize, awburst, awid, awlock, awcache, awprot, awqos},
            {8'(BEATS - 1), 3'd6, 2'b01, 4'd0, 1'b0, 4'd0, 3'd0, 4'd0});
        aw_addr_log.push_back(awaddr);
        if (aw_acc < 64) aw_cyc[aw_acc] = cyc;
        aw_acc++;
      end
      if (bvalid && exp_busy) begin
        b_rcv++;
        if (bresp != 2'b00) exp_err++;
      end
      if (exp_busy && aw_acc - b_rcv > max_out) max_out = aw_acc - b_rcv;
      if (exp_done) begin
        done_pulses++;
        done_cyc = cyc;
        elapsed_exp = cyc - start_cyc;
        exp_busy = 0;
      end
      if (start_i && !was_busy) begin
        start_cyc = cyc; run_n = num_bursts_i;
        aw_acc = 0; w_done = 0; w_beats = 0; b_rcv = 0; exp_err = 0; elapsed_exp = 0;
        exp_busy = 1;
      end
      aw_stall_prev = awvalid && !awready;
      aw_addr_prev  = awaddr;
      w_stall_prev  = wvalid && !wready;
      wdata_prev    = wdata;
      wlast_prev    = wlast;
    end
  end

  task automatic prep(input int stall, input int bdel, input int err_idx, input bit rnd_err);
    stall_en = stall; b_delay = bdel;
    for (int i = 0; i < 64; i++) begin
      if (rnd_err) plan[i] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      else         plan[i] = (i == err_idx) ? 2'b10 : 2'b00;
    end
    aw_addr_log.delete(); wlast_log.delete();
    done_pulses = 0; max_out = 0; aw_valid_cycles = 0; w_valid_cycles = 0;
    first_w32 = 32'hDEAD_BEEF;
  endtask

  task automatic do_start(input int n);
    @(posedge clk); #1;
    start_i = 1; num_bursts_i = 32'(n);
    @(posedge clk); #1;
    start_i = 0;
  endtask

  task automatic wait_idle(input int budget);
    bit ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!exp_busy) begin ok = 1; break; end
    end
    if (!ok) begin
      n_cmp++; n_fail++;
      $display("FAIL run_timeout: got busy expected idle within %0d cycles", budget);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 resetn = 1;
    @(negedge clk);
    chk("rst_state", {busy_o, done_o, awvalid, wvalid, wlast, bready}, 6'b000001);
    chk("rst_elapsed", elapsed_o, 0);
    chk("rst_errors", errs_o, 0);

    // Four bursts, always-ready slave.
    prep(0, 0, -1, 0); do_start(4); wait_idle(5000);
    chk("t1_addr0", aw_addr_log.size() > 0 ? aw_addr_log[0] : 0, 64'h1_0000_0000);
    chk("t1_addr1", aw_addr_log.size() > 1 ? aw_addr_log[1] : 0, 64'h1_0000_1000);
    chk("t1_addr2", aw_addr_log.size() > 2 ? aw_addr_log[2] : 0, 64'h1_0000_2000);
    chk("t1_addr3", aw_addr_log.size() > 3 ? aw_addr_log[3] : 0, 64'h1_0000_3000);
    chk("t1_wlast_n", wlast_log.size(), 4);
    chk("t1_wlast0", wlast_log.size() > 0 ? wlast_log[0] : -1, 63);
    chk("t1_wlast3", wlast_log.size() > 3 ? wlast_log[3] : -1, 255);
    chk("t1_done_pulses", done_pulses, 1);
    chk("t1_busy", busy_o, 0);

    // Slow B: outstanding cap reached; window wraps after four bursts.
    prep(0, 50, -1, 0); do_start(6); wait_idle(5000);
    chk("t2_max_out", max_out, 2);
    chk("t3_wrap4", aw_addr_log.size() > 4 ? aw_addr_log[4] : 0, 64'h1_0000_0000);
    chk("t3_wrap5", aw_addr_log.size() > 5 ? aw_addr_log[5] : 0, 64'h1_0000_1000);

    // Empty run.
    prep(0, 0, -1, 0); do_start(0); wait_idle(100);
    chk("t4_elapsed", elapsed_o, 1);
    chk("t4_done_lat", done_cyc - start_cyc, 1);
    chk("t4_no_axi", aw_valid_cycles + w_valid_cycles, 0);
    chk("t4_done_pulses", done_pulses, 1);

    // Random stalls, SLVERR on burst 2, start pulse while busy must be ignored.
    prep(1, 3, 2, 0); do_start(8);
    repeat (40) @(posedge clk);
    #1 start_i = 1; num_bursts_i = 99;
    @(posedge clk); #1 start_i = 0;
    wait_idle(8000);
    chk("t5_errors", errs_o, 1);
    chk("t5_bursts", aw_addr_log.size(), 8);
    chk("t5_done_pulses", done_pulses, 1);

    // Reset mid-run, then a clean single-burst run.
    prep(1, 5, -1, 0); do_start(3);
    repeat (100) @(posedge clk);
    #1 resetn = 0;
    repeat (2) @(posedge clk);
    #1 resetn = 1;
    @(negedge clk);
    chk("t6_rst_state", {busy_o, awvalid, wvalid, wlast}, 4'b0000);
    chk("t6_rst_elapsed", elapsed_o, 0);
    prep(0, 0, -1, 0); do_start(1); wait_idle(2000);
    chk("t6_addr0", aw_addr_log.size() > 0 ? aw_addr_log[0] : 0, 64'h1_0000_0000);
    chk("t6_beat0_word", first_w32, 0);
    chk("t6_errors", errs_o, 0);

    // Randomized runs.
    for (int r = 0; r < 5; r++) begin
      prep(1, $urandom_range(0, 20), -1, 1);
      do_start($urandom_range(1, 5));
      wait_idle(8000);
      chk("rnd_done_pulses", done_pulses, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
